// File: rtl/uart_rx_frontend.sv
// UART receiver front end: 2-flop synchronizer, 8-bit LSB-first deframer and a small byte FIFO.
// Optional even-parity bit check is enabled by defining UART_RX_PARITY_EN.
module uart_rx_frontend #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic       clk_100p0,
   input  logic       rst_n,
   input  logic       rx_pin,
   output logic [7:0] m_data,
   output logic       m_valid,
   input  logic       m_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       parity_err
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] FullM1 = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HalfM1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [PW:0]   Depth  = (PW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StStart   = 3'd1,
      StData    = 3'd2,
`ifdef UART_RX_PARITY_EN
      StParity  = 3'd3,
`endif
      StStop    = 3'd4,
      StRecover = 3'd5
   } state_e;

   state_e        state_q, state_d;
   logic          sync1_q, sync2_q, rx;
   logic [CW-1:0] cnt_q;
   logic [2:0]    bit_q;
   logic [7:0]    shift_q;
   logic          par_bad_q;
   logic          tick, half_tick;
   logic          push, frame_set, parity_set;

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PW:0]   count_q;
   logic          full, pop, wr_en;
   logic          frame_err_q, overrun_q;

   always_ff @(posedge clk_100p0 or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= rx_pin;
         sync2_q <= sync1_q;
      end
   end

   assign rx        = sync2_q;
   assign tick      = (cnt_q == FullM1);
   assign half_tick = (cnt_q == HalfM1);

   always_ff @(posedge clk_100p0 or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:    if (!rx) state_d = StStart;
         StStart:   if (half_tick) state_d = rx ? StIdle : StData;
`ifdef UART_RX_PARITY_EN
         StData:    if (tick && bit_q == 3'd7) state_d = StParity;
         StParity:  if (tick) state_d = StStop;
`else
         StData:    if (tick && bit_q == 3'd7) state_d = StStop;
`endif
         StStop:    if (tick) state_d = rx ? StIdle : StRecover;
         StRecover: if (rx && tick) state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_comb begin
      push       = (state_q == StStop) && tick && rx && !par_bad_q;
      frame_set  = (state_q == StStop) && tick && !rx;
      parity_set = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_set = (state_q == StParity) && tick && (^{rx, shift_q});
`endif
   end

   // Bit timer reloads at every sample point; in RECOVER it restarts on any low cycle.
   always_ff @(posedge clk_100p0 or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         par_bad_q <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               cnt_q     <= '0;
               bit_q     <= '0;
               par_bad_q <= 1'b0;
            end
            StStart: cnt_q <= half_tick ? '0 : cnt_q + 1'b1;
            StData: begin
               if (tick) begin
                  cnt_q   <= '0;
                  shift_q <= {rx, shift_q[7:1]};
                  bit_q   <= bit_q + 3'd1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
               cnt_q <= tick ? '0 : cnt_q + 1'b1;
               if (tick) par_bad_q <= parity_set;
            end
`endif
            StStop:    cnt_q <= tick ? '0 : cnt_q + 1'b1;
            StRecover: cnt_q <= (!rx || tick) ? '0 : cnt_q + 1'b1;
            default:   cnt_q <= '0;
         endcase
      end
   end

   assign full    = (count_q == Depth);
   assign m_valid = (count_q != '0);
   assign pop     = m_valid && m_ready;
   assign wr_en   = push && (!full || pop);
   assign m_data  = mem_q[rd_ptr_q];

   always_ff @(posedge clk_100p0 or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         if (wr_en) begin
            mem_q[wr_ptr_q] <= shift_q;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         if (wr_en && !pop)      count_q <= count_q + 1'b1;
         else if (!wr_en && pop) count_q <= count_q - 1'b1;
         frame_err_q <= frame_set;
         overrun_q   <= push && full && !pop;
      end
   end

   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

`ifdef UART_RX_PARITY_EN
   logic parity_err_q;
   always_ff @(posedge clk_100p0 or negedge rst_n) begin
      if (!rst_n) parity_err_q <= 1'b0;
      else        parity_err_q <= parity_set;
   end
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Randomized bench for uart_rx_frontend: serializes frames onto rx_pin and compares delivered
// bytes and error pulses against a queue-based reference model.
module tb_uart_rx_frontend;

   localparam int unsigned Cpb   = 8;
   localparam int unsigned Depth = 4;

   logic       clk_100p0, rst_n, rx_pin, m_ready;
   logic [7:0] m_data;
   logic       m_valid, frame_err, overrun, parity_err;

   uart_rx_frontend #(.CLKS_PER_BIT(Cpb), .FIFO_DEPTH(Depth)) dut (
      .clk_100p0 (clk_100p0),
      .rst_n     (rst_n),
      .rx_pin    (rx_pin),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .parity_err(parity_err)
   );

   initial begin
      clk_100p0 = 1'b0;
      forever #5 clk_100p0 = ~clk_100p0;
   end

   int n_tests = 0, n_fail = 0;
   logic [7:0] exp_q [$];
   int exp_push = 0, exp_ferr = 0, exp_ovr = 0, exp_perr = 0;
   int n_deliv = 0, n_ferr = 0, n_ovr = 0, n_perr = 0, n_valid_cyc = 0;
   bit rand_ready = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Monitor: every handshake must match the head of the model queue.
   always @(negedge clk_100p0) begin
      if (rst_n) begin
         if (m_valid) n_valid_cyc++;
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("spurious_byte", 32'(m_data), 32'hFFFF_FFFF);
            end else begin
               check_eq("m_data", 32'(m_data), 32'(exp_q.pop_front()));
            end
            n_deliv++;
         end
         if (frame_err) n_ferr++;
         if (overrun) n_ovr++;
         if (parity_err) n_perr++;
      end
   end

   initial begin
      forever begin
         @(posedge clk_100p0);
         #2;
         if (rand_ready) m_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk_100p0);
         #1;
      end
   endtask

   task automatic drive_bit(input logic v);
      rx_pin = v;
      cycles(Cpb);
   endtask

   // Model decides the byte's fate before the stop bit, so the queue is ready before m_valid.
   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_flip);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit((^b) ^ par_flip);
      if (par_flip) exp_perr++;
`endif
      if (!stop_ok) begin
         exp_ferr++;
      end else if (!par_flip) begin
         if (exp_q.size() >= Depth) begin
            exp_ovr++;
         end else begin
            exp_q.push_back(b);
            exp_push++;
         end
      end
      drive_bit(stop_ok);
      rx_pin = 1'b1;
   endtask

   task automatic drain_and_check(input string tag);
      for (int i = 0; i < 400 && exp_q.size() != 0; i++) cycles(1);
      check_eq({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
      check_eq({tag, "_delivered"}, 32'(n_deliv), 32'(exp_push));
      check_eq({tag, "_frame_err"}, 32'(n_ferr), 32'(exp_ferr));
      check_eq({tag, "_overrun"}, 32'(n_ovr), 32'(exp_ovr));
      check_eq({tag, "_parity_err"}, 32'(n_perr), 32'(exp_perr));
   endtask

   initial begin
      int v0;
      logic [7:0] b;
      bit ok;
      rst_n   = 1'b0;
      rx_pin  = 1'b1;
      m_ready = 1'b0;
      #2;
      check_eq("rst_m_valid", 32'(m_valid), 32'd0);
      check_eq("rst_m_data", 32'(m_data), 32'd0);
      check_eq("rst_errs", 32'({frame_err, overrun, parity_err}), 32'd0);
      cycles(3);
      rst_n = 1'b1;
      cycles(5);

      // Single byte, consumer always ready: m_valid high exactly one cycle.
      m_ready = 1'b1;
      v0 = n_valid_cyc;
      send_frame(8'hA5, 1'b1, 1'b0);
      cycles(10);
      check_eq("a5_valid_cycles", 32'(n_valid_cyc - v0), 32'd1);
      drain_and_check("a5");

      // Short low glitch on idle line.
      rx_pin = 1'b0;
      cycles(3);
      rx_pin = 1'b1;
      cycles(40);
      drain_and_check("glitch");

      // Bad stop bit, then exactly Cpb high cycles before the next frame.
      send_frame(8'h3C, 1'b0, 1'b0);
      cycles(Cpb);
      send_frame(8'h55, 1'b1, 1'b0);
      cycles(10);
      drain_and_check("frame");

      // Fill with consumer stalled: fifth byte overruns.
      m_ready = 1'b0;
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
      cycles(20);
      check_eq("hold_m_valid", 32'(m_valid), 32'd1);
      check_eq("hold_m_data", 32'(m_data), 32'h01);
      check_eq("ovr_pulses", 32'(n_ovr), 32'(exp_ovr));
      m_ready = 1'b1;
      drain_and_check("overrun");

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b1);
      cycles(10);
      send_frame(8'h07, 1'b1, 1'b0);
      cycles(10);
      drain_and_check("parity");
`endif

      // Reset during bit 4 while a byte is waiting.
      m_ready = 1'b0;
      send_frame(8'h11, 1'b1, 1'b0);
      cycles(5);
      check_eq("pre_rst_valid", 32'(m_valid), 32'd1);
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'(8'h7E >> i));
      rx_pin = 1'b0;
      cycles(Cpb / 2);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_valid", 32'(m_valid), 32'd0);
      check_eq("mid_rst_data", 32'(m_data), 32'd0);
      check_eq("mid_rst_errs", 32'({frame_err, overrun, parity_err}), 32'd0);
      exp_push -= exp_q.size();
      exp_q.delete();
      rx_pin = 1'b1;
      cycles(3);
      rst_n   = 1'b1;
      m_ready = 1'b1;
      cycles(20);
      send_frame(8'h7E, 1'b1, 1'b0);
      cycles(10);
      drain_and_check("reset");

      // Random bytes, occasional bad stop bits, random consumer backpressure.
      rand_ready = 1'b1;
      for (int n = 0; n < 14; n++) begin
         b  = 8'($urandom);
         ok = ($urandom_range(0, 4) != 0);
         send_frame(b, ok, 1'b0);
         cycles(ok ? $urandom_range(0, 10) : Cpb + $urandom_range(0, 5));
      end
      rand_ready = 1'b0;
      #3;
      m_ready = 1'b1;
      drain_and_check("random");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_frontend.md
UART_RX_FRONTEND -- requirements
Module: uart_rx_frontend

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clk_100p0 cycles per UART bit (115200 baud at 100 MHz); legal range 4..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, received-byte buffer entries; power of two, 2..16.
REQ-003 SHALL have port clk_100p0, input, 1, the only clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port rx_pin, input, 1, raw asynchronous UART line from board pin ICE_27; idle high.
REQ-006 SHALL have port m_data, output, 8, received byte at FIFO head.
REQ-007 SHALL have port m_valid, output, 1, m_data holds a valid byte.
REQ-008 SHALL have port m_ready, input, 1, core accepts m_data.
REQ-009 SHALL have port frame_err, output, 1, one-cycle pulse when a stop bit is sampled low.
REQ-010 SHALL have port overrun, output, 1, one-cycle pulse when a good byte is dropped because the FIFO is full.
REQ-011 SHALL have port parity_err, output, 1, one-cycle pulse on parity mismatch; tied 0 when UART_RX_PARITY_EN is undefined.

Function
REQ-012 SHALL pass rx_pin through a 2-flop synchronizer whose flops reset to 1; all decoding uses the synchronized value.
REQ-013 SHALL implement an FSM with states IDLE, START, DATA, PARITY (macro only), STOP and RECOVER.
REQ-014 SHALL leave IDLE for START on the first cycle the synchronized line is 0.
REQ-015 SHALL sample the line in START after CLKS_PER_BIT/2 cycles: if 0, go to DATA; if 1, treat it as a glitch and return to IDLE with no output.
REQ-016 SHALL sample each data bit CLKS_PER_BIT cycles after the previous sample, receiving 8 bits LSB first, using a bit counter 0..7.
REQ-017 SHALL push the byte into the FIFO if the stop bit is sampled 1 and no parity error occurred, then return to IDLE.
REQ-018 SHALL, on a stop bit sampled 0, pulse frame_err, discard the byte, and enter RECOVER; RECOVER returns to IDLE only after the line has been 1 for CLKS_PER_BIT consecutive cycles.
REQ-019 SHALL drive m_valid = FIFO not empty; it SHALL rise on the cycle after the stop-bit sample when the FIFO was empty.
REQ-020 SHALL pop the FIFO on any cycle where m_valid and m_ready are both 1; m_data and m_valid SHALL hold while m_valid=1 and m_ready=0.
REQ-021 SHALL, on a push when full with no simultaneous pop, drop the new byte, keep FIFO contents unchanged and pulse overrun.
REQ-022 SHALL, on a push and pop in the same cycle when full, accept both with no overrun and leave the count unchanged.
REQ-023 SHALL use wrapping read/write pointers of log2(FIFO_DEPTH) bits plus a count of log2(FIFO_DEPTH)+1 bits for full/empty.
REQ-024 SHALL count bit timing with a counter of ceil(log2(CLKS_PER_BIT)) bits that reloads on every sample point.

Reset
REQ-025 SHALL, on rst_n=0, immediately force: FSM to IDLE; counters, pointers and count to 0; m_data=0x00; m_valid=0; frame_err, overrun and parity_err to 0; synchronizer to 1.
REQ-026 SHALL discard any frame in progress when reset is asserted mid-frame; after release the next falling edge starts a fresh frame.
REQ-027 SHALL release reset synchronously to clk_100p0 via an external synchronizer; the block itself adds none.

Configuration
REQ-028 SHALL, with UART_RX_PARITY_EN defined, sample one even-parity bit after bit 7 in state PARITY; on mismatch, pulse parity_err and discard the byte, then continue to STOP with normal frame checking.
REQ-029 SHALL, with UART_RX_PARITY_EN undefined, omit the PARITY state (DATA goes directly to STOP) and tie parity_err to 0.

Verification (CLKS_PER_BIT=8, FIFO_DEPTH=4)
REQ-030 SHALL cover: send 0xA5 with 8N1 framing, m_ready=1 -> m_valid pulses one cycle with m_data=0xA5; no error pulses.
REQ-031 SHALL cover: 3-cycle low glitch on an idle line -> no m_valid, FSM back in IDLE, no error pulses.
REQ-032 SHALL cover: send 0x3C with stop bit held 0 -> frame_err one pulse, no m_valid, next 0x55 after 8 high cycles received correctly.
REQ-033 SHALL cover: m_ready=0, send 0x01..0x05 -> 0x05 dropped with one overrun pulse; raise m_ready -> 0x01,0x02,0x03,0x04 delivered in order.
REQ-034 SHALL cover: assert rst_n=0 during bit 4 of a frame -> outputs at reset values immediately; the next full frame 0x7E is received correctly.
REQ-035 SHALL cover, with UART_RX_PARITY_EN defined: send 0x07 with parity bit 0 -> parity_err one pulse, no m_valid; send 0x07 with parity bit 1 -> m_data=0x07.
